// File: rtl/slt_sequencer_if.sv
// Start/busy/done handshake bundle for the digit-serial set-less-than unit.
// The master (controller) issues compares and the slave (slt_sequencer) returns the flag word.
interface slt_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              is_unsigned;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (
        output start, a, b, is_unsigned,
        input  busy, done, result
    );

    modport slave (
        input  start, a, b, is_unsigned,
        output busy, done, result
    );
endinterface

// File: rtl/slt_sequencer.sv
// Multi-cycle slt/sltu unit: compares DIGIT_W bits per cycle from the MSB down.
// Optional macro SLT_SEQ_EARLY_EXIT_EN finishes on the first differing digit.
module slt_sequencer #(
    parameter int DATA_W  = 32,
    parameter int DIGIT_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    slt_sequencer_if.slave  bus
);
    localparam int NDIG  = DATA_W / DIGIT_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    typedef enum logic {IDLE, COMPARE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  opa_p0;
    logic [DATA_W-1:0]  opb_p0;
    logic [CNT_W-1:0]   cnt;
    logic               decided;
    logic               lt;
    logic               res_lt;
    logic               done_q;

    logic [DIGIT_W-1:0] dig_a;
    logic [DIGIT_W-1:0] dig_b;
    logic               diff;
    logic               lt_nxt;
    logic               finish;

    // Flipping the sign bit turns two's-complement order into plain unsigned order.
    function automatic logic [DATA_W-1:0] order_map(input logic [DATA_W-1:0] x,
                                                    input logic uns);
        logic [DATA_W-1:0] m;
        m = x;
        if (!uns) m[DATA_W-1] = ~x[DATA_W-1];
        return m;
    endfunction

    assign dig_a  = opa_p0[DATA_W-1 -: DIGIT_W];
    assign dig_b  = opb_p0[DATA_W-1 -: DIGIT_W];
    assign diff   = !decided && (dig_a != dig_b);
    assign lt_nxt = diff ? (dig_a < dig_b) : lt;

`ifdef SLT_SEQ_EARLY_EXIT_EN
    assign finish = (state == COMPARE) && ((cnt == LAST) || diff);
`else
    assign finish = (state == COMPARE) && (cnt == LAST);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = COMPARE;
            COMPARE: if (finish)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = (state == COMPARE);
        bus.done   = done_q;
        bus.result = {{(DATA_W-1){1'b0}}, res_lt};
    end

    // Operand capture in IDLE, one digit consumed per edge in COMPARE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa_p0  <= '0;
            opb_p0  <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            lt      <= 1'b0;
            res_lt  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    opa_p0  <= order_map(bus.a, bus.is_unsigned);
                    opb_p0  <= order_map(bus.b, bus.is_unsigned);
                    cnt     <= '0;
                    decided <= 1'b0;
                    lt      <= 1'b0;
                end
            end else begin
                opa_p0  <= opa_p0 << DIGIT_W;
                opb_p0  <= opb_p0 << DIGIT_W;
                cnt     <= cnt + CNT_W'(1);
                decided <= decided | diff;
                lt      <= lt_nxt;
                if (finish) begin
                    res_lt <= lt_nxt;
                    done_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_slt_sequencer.sv
// Bench for slt_sequencer: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model of the handshake.
module tb_slt_sequencer;
    localparam int DATA_W  = 32;
    localparam int DIGIT_W = 4;
    localparam int N       = DATA_W / DIGIT_W;
    localparam int LAT_FULL = N + 1;
`ifdef SLT_SEQ_EARLY_EXIT_EN
    localparam int LAT_MSB  = 2;
`else
    localparam int LAT_MSB  = N + 1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    slt_sequencer_if #(.DATA_W(DATA_W)) bus ();
    slt_sequencer #(.DATA_W(DATA_W), .DIGIT_W(DIGIT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: numeric comparison, and busy length from the first differing digit.
    function automatic logic ref_lt(input logic [31:0] x, input logic [31:0] y, input logic uns);
        if (uns) return x < y;
        return $signed(x) < $signed(y);
    endfunction

    function automatic int ref_busy_cycles(input logic [31:0] x, input logic [31:0] y);
`ifdef SLT_SEQ_EARLY_EXIT_EN
        logic [31:0] d;
        d = x ^ y;
        for (int j = 0; j < N; j++)
            if (d[DATA_W-1-DIGIT_W*j -: DIGIT_W] != '0) return j + 1;
`endif
        return N;
    endfunction

    logic        m_busy, m_done, m_lt;
    logic [31:0] m_result;
    int          m_remain;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_result <= '0;
            m_remain <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy   <= 1'b1;
                    m_remain <= ref_busy_cycles(bus.a, bus.b);
                    m_lt     <= ref_lt(bus.a, bus.b, bus.is_unsigned);
                end
            end else begin
                if (m_remain == 1) begin
                    m_busy   <= 1'b0;
                    m_done   <= 1'b1;
                    m_result <= {31'b0, m_lt};
                end
                m_remain <= m_remain - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model busy",   {31'b0, bus.busy}, {31'b0, m_busy});
            check("model done",   {31'b0, bus.done}, {31'b0, m_done});
            check("model result", bus.result, m_result);
        end
    end

    // Called at negedge+1; leaves at negedge+1 of the done cycle.
    task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic uns, input logic [31:0] exp_res, input int exp_lat);
        int got_lat;
        logic [31:0] res;
        got_lat = -1;
        res = 'x;
        bus.a = a; bus.b = b; bus.is_unsigned = uns; bus.start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) check({name, " busy k+1"}, {31'b0, bus.busy}, 32'd1);
            if (bus.done) begin got_lat = c; res = bus.result; end
            #1;
            bus.start = 1'b0;
            if (got_lat >= 0) break;
        end
        check({name, " latency"}, got_lat, exp_lat);
        check({name, " result"}, res, exp_res);
    endtask

    function automatic logic [31:0] pick_boundary(input int i);
        logic [31:0] tbl [6];
        tbl = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
        return tbl[i % 6];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int got_done;
    int done_seen;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.is_unsigned = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset busy",   {31'b0, bus.busy}, 32'd0);
        check("reset done",   {31'b0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        #1 reset = 1'b0;
        @(negedge clk); #1;

        run_one("signed -1<1",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'd1, LAT_MSB);
        run_one("unsigned -1<1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'd0, LAT_MSB);
        run_one("equal",        32'h1234_5678, 32'h1234_5678, 1'b0, 32'd0, LAT_FULL);
        run_one("signed min<max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd1, LAT_MSB);
        run_one("unsigned max<0", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'd0, LAT_MSB);

        // Start during busy is ignored; start in the done cycle is accepted.
        bus.a = 32'd5; bus.b = 32'd9; bus.is_unsigned = 1'b0; bus.start = 1'b1;
        got_done = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done) begin got_done = c; check("ignore result", bus.result, 32'd1); end
            #1;
            bus.start = 1'b0;
            if (c == 3) begin bus.a = 32'd9; bus.b = 32'd5; bus.start = 1'b1; end
            if (got_done >= 0) begin
                bus.a = 32'd3; bus.b = 32'd2; bus.start = 1'b1;
                break;
            end
        end
        check("ignore latency", got_done, LAT_FULL);
        @(negedge clk);
        check("b2b busy", {31'b0, bus.busy}, 32'd1);
        #1 bus.start = 1'b0;
        got_done = -1;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done) begin got_done = c; check("b2b result", bus.result, 32'd0); end
            #1;
            if (got_done >= 0) break;
        end
        check("b2b latency", got_done, LAT_FULL);

        // Reset in cycle k+4 aborts; previous result of 1 must clear.
        run_one("pre-reset", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd1, LAT_MSB);
        bus.a = 32'h0000_0001; bus.b = 32'h0000_0000; bus.is_unsigned = 1'b1; bus.start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            bus.start = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("abort busy",   {31'b0, bus.busy}, 32'd0);
        check("abort result", bus.result, 32'd0);
        check("abort done",   {31'b0, bus.done}, 32'd0);
        @(negedge clk); #1 reset = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("abort no done", done_seen, 0);
        #1;
        run_one("post-reset", 32'h0000_0002, 32'h0000_0007, 1'b1, 32'd1, LAT_FULL);

        // Randomized traffic: starts while busy, back-to-back starts, occasional resets.
        done_seen = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
            #1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 499) == 0) reset = 1'b1;
            bus.start = ($urandom_range(0, 2) == 0);
            bus.is_unsigned = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: begin bus.a = $urandom; bus.b = $urandom; end
                1: begin bus.a = $urandom; bus.b = bus.a; end
                2: begin bus.a = $urandom; bus.b = bus.a ^ (32'd1 << $urandom_range(0, 31)); end
                default: begin
                    bus.a = pick_boundary($urandom_range(0, 5));
                    bus.b = pick_boundary($urandom_range(0, 5));
                end
            endcase
        end
        bus.start = 1'b0;
        check("random activity", {31'b0, done_seen > 50}, 32'd1);
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/slt_sequencer.md
Name: slt_sequencer

Overview:
- Multi-cycle set-less-than unit for the MIPS datapath, used for slt/sltu/slti/sltiu.
- Compares two operands digit-serially from the MSB down, so no full-width subtractor is needed on the compare path.
- Produces the 1-bit less-than flag zero-extended to a DATA_W-bit word, ready for the register-file write mux.
- Controller (or testbench) drives it with a start/busy/done handshake.

Parameters:
- DATA_W, 32, operand and result width.
- DIGIT_W, 4, bits compared per cycle. DATA_W % DIGIT_W must be 0.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a compare; sampled only in IDLE
- a  input  DATA_W  left operand (rs)
- b  input  DATA_W  right operand (rt or immediate, already extended)
- is_unsigned  input  1  1 = sltu semantics, 0 = slt (two's complement)
- busy  output  1  high while in COMPARE
- done  output  1  one-cycle pulse: result updated
- result  output  DATA_W  {(DATA_W-1)'b0, lt}; held until the next completed compare

Behaviour:
- Reset (async, active-high):
  - state=IDLE; busy=0; done=0; result=0.
  - Internal operand registers, digit counter and decided/lt flags cleared.
- States:
  - IDLE: busy=0. If start=1 at a rising edge:
    - latch a, b, is_unsigned;
    - for signed, invert bit DATA_W-1 of both latched operands (this maps signed order onto unsigned order);
    - clear decided and lt; counter=0; go to COMPARE.
  - COMPARE: busy=1. Each edge compares the current top digit of the latched a and b:
    - if decided=0 and the digits differ: decided=1, lt=(digit_a < digit_b);
    - shift both operand registers left by DIGIT_W; counter++.
    - When counter reaches DATA_W/DIGIT_W-1 on this edge (final digit), go to IDLE and, on that same edge, load result[0] with the final lt, clear the upper bits, and set done=1.
- Latency:
  - start high in cycle k; busy high in cycles k+1 .. k+N, where N = DATA_W/DIGIT_W (8 at defaults).
  - done=1 and new result visible in cycle k+N+1.
  - Throughput: one compare per N+1 cycles.
- done: high for exactly one cycle; it clears on the next edge regardless of inputs.
- start handling:
  - start while busy=1 is ignored: not queued, and operands are not resampled.
  - start in the same cycle that done=1 is accepted, because the state is already IDLE.
- Operand stability: a, b and is_unsigned only need to be valid in the start cycle.
- Equal operands: decided stays 0, so lt=0 and result=0.
- Boundaries:
  - Signed: 0x80000000 < 0x7FFFFFFF gives 1.
  - Unsigned: 0xFFFFFFFF < 0 gives 0.
- Reset mid-COMPARE: aborts immediately. No done pulse; result=0.
- result changes only on the done edge or on reset.

Optional Feature:
- Macro: SLT_SEQ_EARLY_EXIT_EN
- Defined:
  - In COMPARE, the first edge that sets decided=1 also finishes the operation: go to IDLE, load result, pulse done.
  - A difference found in digit j (0 = MSB digit) gives done in cycle k+j+2.
  - Equal operands still take the full N cycles.
- Undefined: fixed latency of N+1 cycles as specified above. Result values are identical in both builds.

Test Plan:
- Reset, then signed compare a=0xFFFFFFFF (-1), b=0x00000001 -> busy in cycles k+1..k+8; done pulse in k+9; result=0x00000001.
- Unsigned compare of the same operands -> result=0x00000000, done in k+9.
- a=b=0x12345678, signed -> result=0; done timing as above. With SLT_SEQ_EARLY_EXIT_EN, latency is still 9 cycles.
- Signed a=0x80000000, b=0x7FFFFFFF -> result=1. With SLT_SEQ_EARLY_EXIT_EN, done in cycle k+2.
- Pulse start again in cycle k+3 with different operands while busy -> ignored; first result is correct; a new start in the done cycle is accepted, and busy rises the next cycle.
- Assert reset in cycle k+4 of a compare -> busy=0 and result=0 immediately; no done pulse; the next start runs normally.
